// File: rtl/pixel_fb_writer_if.sv
// Pixel stream, swap control and frame buffer write port of the frame buffer writer.
interface pixel_fb_writer_if #(
   parameter int ADDR_WIDTH = 17
);
   logic [23:0]           pixel_axis_tdata;
   logic                  pixel_axis_tvalid;
   logic                  pixel_axis_tready;
   logic                  swap_req;
   logic                  restart;
   logic [ADDR_WIDTH-1:0] fb_addr;
   logic [23:0]           fb_wdata;
   logic                  fb_we;
   logic                  display_buf;
   logic                  frame_done;
   logic [7:0]            frame_count;

   // Source side: shader stream and display control.
   modport master (
      output pixel_axis_tdata, pixel_axis_tvalid, swap_req, restart,
      input  pixel_axis_tready, fb_addr, fb_wdata, fb_we, display_buf,
             frame_done, frame_count
   );

   // Writer side.
   modport slave (
      input  pixel_axis_tdata, pixel_axis_tvalid, swap_req, restart,
      output pixel_axis_tready, fb_addr, fb_wdata, fb_we, display_buf,
             frame_done, frame_count
   );
endinterface

// File: rtl/pixel_fb_writer.sv
// Raster-order pixel sink writing into one half of a double-buffered frame
// buffer; stalls after each frame until the display side requests a swap.
module pixel_fb_writer #(
   parameter int H_RES      = 320,
   parameter int V_RES      = 180,
   parameter int ADDR_WIDTH = 17
) (
   input logic               aclk,
   input logic               areset,
   pixel_fb_writer_if.slave  bus
);
   localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
   localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
   localparam logic [ADDR_WIDTH-1:0] BASE   = ADDR_WIDTH'(H_RES * V_RES);
   localparam logic [ADDR_WIDTH-1:0] HRES_A = ADDR_WIDTH'(H_RES);

   typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

   state_t                state, state_nxt;
   logic [XW-1:0]         x;
   logic [YW-1:0]         y;
   logic                  write_buf;
   logic                  hs;
   logic                  x_last, y_last;
   logic [ADDR_WIDTH-1:0] pix_addr;

   assign hs       = bus.pixel_axis_tvalid & bus.pixel_axis_tready;
   assign x_last   = (x == XW'(H_RES - 1));
   assign y_last   = (y == YW'(V_RES - 1));
   assign pix_addr = (write_buf ? BASE : '0) + ADDR_WIDTH'(y) * HRES_A + ADDR_WIDTH'(x);

   // State register.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) state <= FILL;
      else        state <= state_nxt;
   end

   // Next state: restart always lands in FILL without swapping; a swap
   // request only counts once the frame is complete (HOLD).
   always_comb begin
      state_nxt = state;
      if (bus.restart)
         state_nxt = FILL;
      else if (state == FILL) begin
         if (hs && x_last && y_last) state_nxt = HOLD;
      end else if (bus.swap_req)
         state_nxt = FILL;
   end

   // Outputs from state: tready is forced low while reset is held.
   always_comb begin
      bus.pixel_axis_tready = (state == FILL) && !areset;
   end

   // Datapath: position counters, one-cycle-latency BRAM write, buffer swap.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         x               <= '0;
         y               <= '0;
         write_buf       <= 1'b0;
         bus.display_buf <= 1'b1;
         bus.fb_we       <= 1'b0;
         bus.fb_addr     <= '0;
         bus.fb_wdata    <= '0;
         bus.frame_done  <= 1'b0;
         bus.frame_count <= '0;
      end else begin
         bus.fb_we      <= 1'b0;
         bus.frame_done <= 1'b0;
         if (bus.restart) begin
            x <= '0;
            y <= '0;
         end else if (hs) begin
            bus.fb_we    <= 1'b1;
            bus.fb_addr  <= pix_addr;
            bus.fb_wdata <= bus.pixel_axis_tdata;
            if (x_last) begin
               x <= '0;
               if (y_last) begin
                  y               <= '0;
                  bus.frame_done  <= 1'b1;
                  bus.frame_count <= bus.frame_count + 8'd1;
               end else
                  y <= y + YW'(1);
            end else
               x <= x + XW'(1);
         end else if (state == HOLD && bus.swap_req) begin
            write_buf       <= ~write_buf;
            bus.display_buf <= write_buf;
         end
      end
   end
endmodule

// File: tb/tb_pixel_fb_writer.sv
// Directed, table-driven bench for pixel_fb_writer with a 4x2 frame.
module tb_pixel_fb_writer;
   localparam int AW = 4;

   typedef struct {
      logic        tv;
      logic [23:0] d;
      logic        sw;
      logic        rs;
      logic        we;
      logic [AW-1:0] a;
      logic [23:0] wd;
      logic        done;
      logic        tr;
      logic        disp;
      logic [7:0]  fc;
   } vec_t;

   logic aclk = 1'b0;
   logic areset = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   vec_t          vecs[$];
   logic [AW-1:0] la = '0;
   logic [23:0]   ld = '0;
   logic          cdisp = 1'b1;
   logic [7:0]    cfc = '0;

   pixel_fb_writer_if #(.ADDR_WIDTH(AW)) bus ();

   pixel_fb_writer #(.H_RES(4), .V_RES(2), .ADDR_WIDTH(AW)) dut (
      .aclk(aclk), .areset(areset), .bus(bus)
   );

   always #5 aclk = ~aclk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Append one cycle: inputs plus the outputs expected after that edge.
   task automatic add(input logic tv, input logic [23:0] d, input logic sw, input logic rs,
                      input logic we, input logic [AW-1:0] a, input logic done, input logic tr);
      if (we) begin la = a; ld = d; end
      vecs.push_back('{tv, d, sw, rs, we, la, ld, done, tr, cdisp, cfc});
   endtask

   task automatic drive(input logic tv, input logic [23:0] d, input logic sw, input logic rs);
      bus.pixel_axis_tvalid = tv;
      bus.pixel_axis_tdata  = d;
      bus.swap_req          = sw;
      bus.restart           = rs;
   endtask

   task automatic check_all(input string tag, input logic we, input logic [AW-1:0] a,
                            input logic [23:0] wd, input logic done, input logic tr,
                            input logic disp, input logic [7:0] fc);
      n_vec++;
      chk({tag, " fb_we"},       32'(bus.fb_we),             32'(we));
      chk({tag, " fb_addr"},     32'(bus.fb_addr),           32'(a));
      chk({tag, " fb_wdata"},    32'(bus.fb_wdata),          32'(wd));
      chk({tag, " frame_done"},  32'(bus.frame_done),        32'(done));
      chk({tag, " tready"},      32'(bus.pixel_axis_tready), 32'(tr));
      chk({tag, " display_buf"}, 32'(bus.display_buf),       32'(disp));
      chk({tag, " frame_count"}, 32'(bus.frame_count),       32'(fc));
   endtask

   initial begin
      drive(1'b0, 24'h0, 1'b0, 1'b0);

      // Frame 1 into buffer 0: addresses 0..7, back-to-back.
      for (int k = 1; k <= 8; k++) begin
         if (k == 8) cfc = 8'd1;
         add(1'b1, 24'(k), 1'b0, 1'b0, 1'b1, AW'(k - 1), k == 8, k < 8);
      end
      // HOLD with tvalid high: nothing written.
      for (int k = 0; k < 10; k++) add(1'b1, 24'hFFFFFF, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      // Swap: display 1->0, tready back next cycle.
      cdisp = 1'b0;
      add(1'b1, 24'hFFFFFF, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1);
      // Frame 2 into buffer 1: addresses 8..15.
      for (int k = 1; k <= 8; k++) begin
         if (k == 8) cfc = 8'd2;
         add(1'b1, 24'h10 + 24'(k), 1'b0, 1'b0, 1'b1, AW'(7 + k), k == 8, k < 8);
      end
      cdisp = 1'b1;
      add(1'b0, 24'h0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1);
      // Frame 3, gapped across the line boundary, swap on the last edge lost.
      add(1'b1, 24'h21, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1);
      add(1'b1, 24'h22, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b1);
      add(1'b1, 24'h23, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0, 1'b1);
      add(1'b1, 24'h24, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b1);
      add(1'b0, 24'h99, 1'b0, 1'b0, 1'b0, '0,   1'b0, 1'b1);
      add(1'b0, 24'h99, 1'b0, 1'b0, 1'b0, '0,   1'b0, 1'b1);
      add(1'b1, 24'h25, 1'b0, 1'b0, 1'b1, 4'd4, 1'b0, 1'b1);
      add(1'b0, 24'h99, 1'b0, 1'b0, 1'b0, '0,   1'b0, 1'b1);
      add(1'b1, 24'h26, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b1);
      add(1'b1, 24'h27, 1'b0, 1'b0, 1'b1, 4'd6, 1'b0, 1'b1);
      cfc = 8'd3;
      add(1'b1, 24'h28, 1'b1, 1'b0, 1'b1, 4'd7, 1'b1, 1'b0);
      add(1'b0, 24'h0,  1'b0, 1'b0, 1'b0, '0,   1'b0, 1'b0);
      cdisp = 1'b0;
      add(1'b0, 24'h0,  1'b1, 1'b0, 1'b0, '0,   1'b0, 1'b1);
      // Frame 4 into buffer 1, restart on pixel 5 drops it and rebases.
      for (int k = 1; k <= 4; k++) add(1'b1, 24'h30 + 24'(k), 1'b0, 1'b0, 1'b1, AW'(7 + k), 1'b0, 1'b1);
      add(1'b1, 24'h35, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b1);
      for (int k = 1; k <= 8; k++) begin
         if (k == 8) cfc = 8'd4;
         add(1'b1, 24'h40 + 24'(k), 1'b0, 1'b0, 1'b1, AW'(7 + k), k == 8, k < 8);
      end
      cdisp = 1'b1;
      add(1'b0, 24'h0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1);
      add(1'b1, 24'h51, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1);
      add(1'b1, 24'h52, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b1);

      // Reset state.
      @(posedge aclk); #1;
      check_all("reset", 1'b0, '0, 24'h0, 1'b0, 1'b0, 1'b1, 8'd0);
      @(negedge aclk);
      areset = 1'b0;

      foreach (vecs[i]) begin
         drive(vecs[i].tv, vecs[i].d, vecs[i].sw, vecs[i].rs);
         @(posedge aclk); #1;
         check_all($sformatf("vec%0d", i), vecs[i].we, vecs[i].a, vecs[i].wd,
                   vecs[i].done, vecs[i].tr, vecs[i].disp, vecs[i].fc);
      end

      // Async reset between edges while a write is in flight.
      #2;
      areset = 1'b1;
      #1;
      n_vec++;
      chk("async fb_we",      32'(bus.fb_we),             32'd0);
      chk("async frame_done", 32'(bus.frame_done),        32'd0);
      chk("async tready",     32'(bus.pixel_axis_tready), 32'd0);
      chk("async fb_addr",    32'(bus.fb_addr),           32'd0);
      @(negedge aclk);
      areset = 1'b0;
      drive(1'b1, 24'hABCDEF, 1'b0, 1'b0);
      @(posedge aclk); #1;
      check_all("post_reset", 1'b1, '0, 24'hABCDEF, 1'b0, 1'b1, 1'b1, 8'd0);
      drive(1'b0, 24'h0, 1'b0, 1'b0);
      @(posedge aclk); #1;
      check_all("post_idle", 1'b0, '0, 24'hABCDEF, 1'b0, 1'b1, 1'b1, 8'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/pixel_fb_writer.md
Name: pixel_fb_writer

Overview:
- Sink end of the shader's 24-bit pixel AXI-stream.
- Accepts pixels in raster order, tracks x/y position, and writes each pixel into one half of a double-buffered frame buffer BRAM.
- When a frame completes, it stalls the stream (tready low) until the display side requests a buffer swap.
- Sits between the shading pipeline output and the video-out frame buffer.

Parameters:
- H_RES, 320, pixels per line.
- V_RES, 180, lines per frame.
- ADDR_WIDTH, 17, frame buffer address width; must hold 2*H_RES*V_RES.

Ports:
- aclk  input  1  system clock.
- areset  input  1  reset; asynchronous, active-high.
- pixel_axis_tdata  input  24  pixel {R[23:16],G[15:8],B[7:0]}.
- pixel_axis_tvalid  input  1  pixel valid.
- pixel_axis_tready  output  1  writer can accept a pixel.
- swap_req  input  1  display-side request to swap buffers; single-cycle or level.
- restart  input  1  synchronous abort of the current frame; restarts at pixel (0,0).
- fb_addr  output  ADDR_WIDTH  BRAM write address.
- fb_wdata  output  24  BRAM write data.
- fb_we  output  1  BRAM write enable.
- display_buf  output  1  buffer the display reads (0 or 1).
- frame_done  output  1  one-cycle pulse when the last pixel of a frame is accepted.
- frame_count  output  8  count of completed frames; wraps 255->0.

Behaviour:
- Reset (async, areset=1):
  - state=FILL; x=0, y=0; write_buf=0; display_buf=1.
  - fb_we=0, fb_addr=0, fb_wdata=0, frame_done=0, frame_count=0.
  - pixel_axis_tready=0 while areset is high.
- State machine:
  - FILL: pixel_axis_tready=1.
  - HOLD: pixel_axis_tready=0.
  - tready is combinational from state and reset only; it does not depend on tvalid.
- Handshake (tvalid & tready at a rising edge):
  - Next cycle: fb_we=1, fb_wdata=tdata, fb_addr=write_buf*H_RES*V_RES + y*H_RES + x, using the pre-increment x/y.
  - Write latency is 1 cycle.
  - fb_we=0 in every cycle with no handshake on the prior edge.
  - fb_addr/fb_wdata hold their last values when fb_we=0.
- Counters:
  - x increments on each handshake.
  - At x=H_RES-1: x->0, y increments.
  - At x=H_RES-1 and y=V_RES-1: x->0, y->0, state->HOLD, frame_done pulses with the final fb_we (same cycle), frame_count increments.
- HOLD:
  - When swap_req=1: write_buf toggles, display_buf takes the old write_buf value, state->FILL.
  - tready rises the cycle after the swap edge.
- swap_req in FILL is ignored.
  - This includes the same edge as the last-pixel handshake; that request is lost, and a new swap_req is needed in HOLD.
- restart (highest priority after reset):
  - x=0, y=0, state->FILL; write_buf and display_buf unchanged.
  - Any handshake on the same edge is discarded: no fb_we, no counter advance, no frame_done.
  - restart in HOLD returns to FILL without swapping, so the just-completed frame gets overwritten.
- tvalid low mid-frame: counters hold, no writes, no timeout.
- Address arithmetic:
  - Unsigned; the base offset is the constant H_RES*V_RES.
  - No wrap beyond 2*H_RES*V_RES-1 is possible by construction.
- Reset asserted mid-frame: all state is cleared immediately and asynchronously; an in-flight fb_we is dropped.

Test Plan (bench uses H_RES=4, V_RES=2):
- Reset release, tvalid=1 with 8 pixels 0x000001..0x000008 back-to-back:
  - fb_addr 0..7 with matching data on consecutive cycles, fb_we high for 8 cycles.
  - frame_done pulses with addr 7; frame_count=1; tready=0 afterward.
- In HOLD, hold tvalid=1 for 10 cycles, then pulse swap_req:
  - No fb_we during HOLD.
  - display_buf 1->0; tready=1 next cycle.
  - Next 8 pixels write addresses 8..15.
- Gapped input (tvalid toggling 1,0,0,1,...) across the line boundary at x=3:
  - Writes go to addr 3 then 4 with no gap writes; y advances only on a handshake.
- swap_req asserted on the same edge as the last-pixel handshake:
  - Stays in HOLD, display_buf unchanged.
  - A second swap_req two cycles later swaps.
- restart during pixel 5 of a frame, with tvalid=1:
  - Pixel 5 is not written.
  - The following pixel is written at the buffer base (addr 0 or 8 per write_buf); no frame_done.
- Async reset asserted mid-frame between clock edges:
  - fb_we, frame_done and tready go to 0 immediately.
  - After release, writes restart at addr 0; display_buf=1; frame_count=0.
